hamming_stream_encoder: RTL and testbench

HAMMING_STREAM_ENCODER -- requirements
Module: hamming_stream_encoder

---
 rtl/hamming_stream_encoder.sv | 193 +++++++++++++++++++
 tb/tb_hamming_stream_encoder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_stream_encoder.sv
// ---------------------------------------------------------------------------
// hamming_stream_encoder
//
// Streaming Hamming encoder with a 2-entry output FIFO. Each word is encoded
// when it is accepted on the input handshake, and the finished codeword is
// stored in the FIFO until the consumer takes it.
//
// Configuration macro:
//   HAMMING_SECDED_EN  - when defined, appends an overall parity bit at
//                        out_code[CODE_W-1] (SEC-DED). When undefined,
//                        CODE_W = DATA_W + PAR_W.
//
// Parameters:
//   DATA_W  - data bits per codeword
//   PAR_W   - Hamming parity bits per codeword
//
// Ports:
//   clk             in   clock, all state updates on the rising edge
//   rst             in   synchronous active-high reset
//   in_valid        in   input word offered
//   in_ready        out  block can accept a word this cycle
//   in_data         in   data word, bit 0 is data bit 1
//   in_parity_type  in   0 = even parity, 1 = odd parity (per word)
//   out_valid       out  out_code holds a valid codeword
//   out_ready       in   consumer accepts out_code
//   out_code        out  codeword, bit i is code position i+1
// ---------------------------------------------------------------------------
module hamming_stream_encoder #(
  parameter int DATA_W = 4,
  parameter int PAR_W  = 3,
`ifdef HAMMING_SECDED_EN
  localparam int CODE_W = DATA_W + PAR_W + 1
`else
  localparam int CODE_W = DATA_W + PAR_W
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_parity_type,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code
);

  // Width of the plain Hamming part (without the optional overall bit).
  localparam int HAM_W = DATA_W + PAR_W;

  // Reject parameter sets that cannot form a (possibly shortened) code.
  if ((DATA_W < 1) || (DATA_W > ((1 << PAR_W) - PAR_W - 1))) begin : g_bad_data_w
    $error("hamming_stream_encoder: DATA_W=%0d is not valid for PAR_W=%0d",
           DATA_W, PAR_W);
  end

  // The highest parity position must land inside the codeword.
  if ((PAR_W >= 2) && ((1 << (PAR_W - 1)) > HAM_W)) begin : g_bad_short
    $error("hamming_stream_encoder: parity position %0d exceeds code width %0d",
           (1 << (PAR_W - 1)), HAM_W);
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } fifo_state_e;

  // -------------------------------------------------------------------------
  // Encoder. Data bits are placed at non-power-of-two positions in ascending
  // order; each data bit at position pos toggles every parity bit k for which
  // bit k of pos is set, which is exactly "parity k covers positions with
  // bit k set". Parity bit k then goes to position 2^k.
  // -------------------------------------------------------------------------
  function automatic logic [CODE_W-1:0] encode_word(
    input logic [DATA_W-1:0] data,
    input logic              ptype
  );
    logic [CODE_W-1:0] code;
    logic [PAR_W-1:0]  par;
    logic [PAR_W-1:0]  par_shift;
    logic [DATA_W-1:0] rest;
    code = '0;
    par  = '0;
    rest = data;
    for (int pos = 1; pos <= HAM_W; pos++) begin
      if ((pos & (pos - 32'sd1)) != 32'sd0) begin
        code = code | (CODE_W'(rest[0]) << (pos - 32'sd1));
        par  = par ^ (PAR_W'(pos) & {PAR_W{rest[0]}});
        rest = rest >> 1;
      end
    end
    par       = par ^ {PAR_W{ptype}};
    par_shift = par;
    for (int k = 0; k < PAR_W; k++) begin
      code      = code | (CODE_W'(par_shift[0]) << ((32'sd1 << k) - 32'sd1));
      par_shift = par_shift >> 1;
    end
`ifdef HAMMING_SECDED_EN
    code[CODE_W-1] = (^code[HAM_W-1:0]) ^ ptype;
`endif
    return code;
  endfunction

  fifo_state_e       state_r;
  fifo_state_e       state_nxt_s;
  logic [CODE_W-1:0] head_r;
  logic [CODE_W-1:0] tail_r;
  logic [CODE_W-1:0] head_nxt_s;
  logic [CODE_W-1:0] tail_nxt_s;
  logic              out_valid_r;
  logic [CODE_W-1:0] enc_s;
  logic              push_s;
  logic              pop_s;

  // in_ready depends only on FIFO occupancy and reset, never on out_ready.
  assign in_ready  = (~rst) & (state_r != TWO);
  assign push_s    = in_valid & in_ready;
  assign pop_s     = out_valid_r & out_ready;
  assign enc_s     = encode_word(in_data, in_parity_type);
  assign out_valid = out_valid_r;
  // head_r is cleared whenever it is vacated, so it reads 0 while empty.
  assign out_code  = head_r;

  // FIFO next-state and entry update selection.
  always_comb begin
    state_nxt_s = state_r;
    head_nxt_s  = head_r;
    tail_nxt_s  = tail_r;
    case (state_r)
      EMPTY: begin
        if (push_s) begin
          state_nxt_s = ONE;
          head_nxt_s  = enc_s;
        end else begin
          state_nxt_s = EMPTY;
        end
      end
      ONE: begin
        if (push_s && pop_s) begin
          state_nxt_s = ONE;
          head_nxt_s  = enc_s;
        end else if (push_s) begin
          state_nxt_s = TWO;
          tail_nxt_s  = enc_s;
        end else if (pop_s) begin
          state_nxt_s = EMPTY;
          head_nxt_s  = '0;
        end else begin
          state_nxt_s = ONE;
        end
      end
      TWO: begin
        // in_ready is low here, so only a pop can happen.
        if (pop_s) begin
          state_nxt_s = ONE;
          head_nxt_s  = tail_r;
          tail_nxt_s  = '0;
        end else begin
          state_nxt_s = TWO;
        end
      end
      default: begin
        state_nxt_s = EMPTY;
        head_nxt_s  = '0;
        tail_nxt_s  = '0;
      end
    endcase
  end

  // FIFO state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FIFO storage and registered out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r      <= '0;
      tail_r      <= '0;
      out_valid_r <= 1'b0;
    end else begin
      head_r      <= head_nxt_s;
      tail_r      <= tail_nxt_s;
      out_valid_r <= (state_nxt_s != EMPTY);
    end
  end

endmodule

// File: tb/tb_hamming_stream_encoder.sv
module tb_hamming_stream_encoder;

`ifdef HAMMING_SECDED_EN
  localparam int CW = 8;
`else
  localparam int CW = 7;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_data;
  logic          in_parity_type;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_code;

  int checks = 0;
  int errors = 0;

  logic [CW-1:0] exp_q[$];

  // Hand-computed even-parity Hamming(7,4) codes for data 0..15.
  logic [6:0] even_tab [16] = '{7'h00, 7'h07, 7'h19, 7'h1E, 7'h2A, 7'h2D, 7'h33, 7'h34,
                                7'h4B, 7'h4C, 7'h52, 7'h55, 7'h61, 7'h66, 7'h78, 7'h7F};
  // Odd parity flips all three parity positions (1, 2, 4).
  localparam logic [6:0] ODD_FLIP = 7'h0B;

  always #5 clk = ~clk;

  hamming_stream_encoder #(.DATA_W(4), .PAR_W(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_parity_type (in_parity_type),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_code       (out_code)
  );

  function automatic logic [CW-1:0] full_code(input logic [6:0] c7, input logic pt);
`ifdef HAMMING_SECDED_EN
    return {(^c7) ^ pt, c7};
`else
    return c7;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on each output transfer, checks hold while stalled.
  logic [CW-1:0] held_code;
  bit            held = 0;
  int            run_len = 0;
  int            max_run = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (held) check("stall_hold", 32'(out_code), 32'(held_code));
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got %h expected no output (t=%0t)", out_code, $time);
          end else begin
            check("code", 32'(out_code), 32'(exp_q.pop_front()));
          end
          held = 0;
        end else begin
          held      = 1;
          held_code = out_code;
        end
      end else begin
        run_len = 0;
        held    = 0;
        check("idle_code_zero", 32'(out_code), 32'd0);
      end
    end else begin
      held    = 0;
      run_len = 0;
    end
  end

  // Offer one word; called at posedge+1, returns at posedge+1 after acceptance.
  task automatic send(input logic [3:0] d, input logic pt, input logic [6:0] c7);
    int waited = 0;
    in_valid       = 1'b1;
    in_data        = d;
    in_parity_type = pt;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 50 cycles (t=%0t)", $time);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      exp_q.push_back(full_code(c7, pt));
      #1;
      in_valid       = 1'b0;
      in_data        = ~d;   // junk while idle must be ignored
      in_parity_type = ~pt;
    end
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  bit stop_tog;

  initial begin
    rst            = 1'b1;
    in_valid       = 1'b0;
    in_data        = 4'h0;
    in_parity_type = 1'b0;
    out_ready      = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_code", 32'(out_code), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Directed vectors.
    send(4'b1011, 1'b0, 7'h55);
    send(4'b1011, 1'b1, 7'h5E);
    send(4'b0000, 1'b1, 7'h0B);
    send(4'b0000, 1'b0, 7'h00);
    drain();

    // Backpressure: two accepts fill the FIFO, third waits.
    out_ready = 1'b0;
    send(4'd3, 1'b0, 7'h1E);
    send(4'd12, 1'b1, 7'h61 ^ ODD_FLIP);
    @(negedge clk);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_out_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    fork
      send(4'd5, 1'b0, 7'h2D);
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // 16 back-to-back words at full rate.
    max_run = 0;
    for (int i = 0; i < 16; i++) send(4'(i), 1'b0, even_tab[i]);
    drain();
    check("stream_run", 32'(max_run), 32'd16);

    // Same kind of stream with random out_ready stalls, mixed parity type.
    stop_tog = 0;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          logic [3:0] dv;
          logic       pt;
          dv = 4'(15 - i);
          pt = i[0];
          send(dv, pt, even_tab[15 - i] ^ (pt ? ODD_FLIP : 7'h00));
        end
        stop_tog = 1;
      end
      begin
        while (!stop_tog) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset with two words buffered: both are discarded.
    out_ready = 1'b0;
    send(4'd9, 1'b0, 7'h4C);
    send(4'd6, 1'b1, 7'h33 ^ ODD_FLIP);
    @(negedge clk);
    check("two_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_code", 32'(out_code), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("midrst_release_in_ready", 32'(in_ready), 32'd1);
    repeat (5) @(negedge clk);
    check("midrst_no_output", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    send(4'd14, 1'b1, 7'h78 ^ ODD_FLIP);
    drain();

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
